bus_ram_wait: RTL

Parametrised memory slave for the CPU's Avalon-style data/instruction bus; the successor to the fixed-behaviour bench RAM. It provides configurable depth, base address and init image, plus a wait-state engine (none / fixed / pseudo-random) that exercises the CPU's `waitrequest` handling. It also flags protocol and address errors on a `fault` output. It sits directly on the `mips_cpu_bus` bus ports in every CPU testbench.

---
 rtl/bus_ram_pkg.sv | 20 ++
 rtl/bus_wait_gen.sv | 92 +++++++++
 rtl/bus_ram_wait.sv | 81 ++++++++
 3 files changed

// File: rtl/bus_ram_pkg.sv
// Shared types and constants for the bus RAM slave and its wait-state generator.
package bus_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int WAIT_NONE   = 0;
    localparam int WAIT_FIXED  = 1;
    localparam int WAIT_RANDOM = 2;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/bus_wait_gen.sv
// Wait-state engine: picks a stall count per transfer, runs the IDLE/STALL FSM and
// reports when a transfer completes, collides (read and write together) or is abandoned.
module bus_wait_gen
    import bus_ram_pkg::*;
#(
    parameter int          WAIT_MODE   = WAIT_NONE,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic read_i,
    input  logic write_i,
    output logic waitrequest_o,
    output logic complete_o,
    output logic conflict_o,
    output logic abort_o
);

    localparam logic [4:0] STALL_MOD = 5'(WAIT_CYCLES + 1);
    localparam logic [3:0] FIXED_N   = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  stallCount;
    logic        req;

    assign req = read_i | write_i;

    always_comb begin
        stallCount = 4'd0;
        if (WAIT_MODE == WAIT_FIXED) begin
            stallCount = FIXED_N;
        end else if (WAIT_MODE == WAIT_RANDOM) begin
            stallCount = 4'({1'b0, lfsr_q[3:0]} % STALL_MOD);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // A simultaneous read and write is refused outright and never consumes an LFSR step.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lfsr_d        = lfsr_q;
        waitrequest_o = 1'b0;
        complete_o    = 1'b0;
        conflict_o    = 1'b0;
        abort_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_i && write_i) begin
                    conflict_o = 1'b1;
                end else if (req) begin
                    lfsr_d = lfsr_next(lfsr_q);
                    if (stallCount == 4'd0) begin
                        complete_o = 1'b1;
                    end else begin
                        waitrequest_o = 1'b1;
                        cnt_d         = stallCount - 4'd1;
                        state_d       = STALL;
                    end
                end
            end
            STALL: begin
                if (!req) begin
                    abort_o = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    waitrequest_o = 1'b1;
                    cnt_d         = cnt_q - 4'd1;
                end else begin
                    complete_o = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/bus_ram_wait.sv
// Avalon-style memory slave for the CPU bus: word RAM with lane writes, registered
// read data, configurable wait states and a one-cycle fault pulse for bad accesses.
module bus_ram_wait
    import bus_ram_pkg::*;
#(
    parameter string       RAM_INIT_FILE = "",
    parameter logic [31:0] ADDR_BASE     = 32'hBFC0_0000,
    parameter int          DEPTH_WORDS   = 4096,
    parameter int          WAIT_MODE     = WAIT_NONE,
    parameter int          WAIT_CYCLES   = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        fault
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      offset;
    logic             addrValid;
    logic [IDX_W-1:0] wordIdx;
    logic             complete, conflict, abort;
    logic [31:0]      readdata_q;
    logic             fault_q;

    // Addresses below the base wrap to a huge offset, so one compare covers both bounds.
    assign offset    = address - ADDR_BASE;
    assign addrValid = (offset < SPAN_BYTES) && (address[1:0] == 2'b00);
    assign wordIdx   = offset[IDX_W+1:2];

    bus_wait_gen #(
        .WAIT_MODE   (WAIT_MODE),
        .WAIT_CYCLES (WAIT_CYCLES),
        .LFSR_SEED   (LFSR_SEED)
    ) u_wait_gen (
        .clk_i         (clk),
        .rst_ni        (reset),
        .read_i        (read),
        .write_i       (write),
        .waitrequest_o (waitrequest),
        .complete_o    (complete),
        .conflict_o    (conflict),
        .abort_o       (abort)
    );

    always_ff @(posedge clk) begin
        if (reset && complete && write && addrValid) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    mem[wordIdx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata_q <= 32'h0;
            fault_q    <= 1'b0;
        end else begin
            fault_q <= (complete && !addrValid) || conflict || abort;
            if (complete && read) begin
                readdata_q <= addrValid ? mem[wordIdx] : 32'h0;
            end
        end
    end

    assign readdata = readdata_q;
    assign fault    = fault_q;

endmodule
